aes_round_ctrl: RTL

Iterative AES encryption round sequencer. Holds the 128-bit cipher state and runs it through a shared round datapath (sub_bytes -> shift_rows -> mix_col, with mix_col bypassed on the final round) once per round. Performs AddRoundKey itself and requests round keys by index from the key schedule. Sits between the block input/output handshakes and the round datapath.

---
 rtl/aes_round_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: owns the cipher state, applies AddRoundKey,
// and drives a shared external round datapath once per round.
module aes_round_ctrl #(
  parameter int NR     = 10,
  parameter int DP_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] dp_in,
  output logic         dp_start,
  output logic         dp_last,
  input  logic [127:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fsm_t;

  localparam logic [3:0] LAST      = 4'(NR);
  localparam bit         NO_WAIT   = (DP_LAT == 0);
  localparam logic [2:0] WAIT_INIT = (DP_LAT > 0) ? 3'(DP_LAT - 1) : 3'd0;

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [2:0]   wait_cnt;
  logic         capture;
  logic [127:0] next_state;

  // The datapath sees the held cipher state directly, so dp_in is stable for the whole round.
  assign dp_in = state_reg;

  always_comb begin
    capture    = ((fsm == ISSUE) && NO_WAIT) || ((fsm == WAIT) && (wait_cnt == 3'd0));
    next_state = dp_out ^ rk;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm       <= IDLE;
      state_reg <= '0;
      out_data  <= '0;
      round     <= '0;
      rk_idx    <= '0;
      wait_cnt  <= '0;
      dp_start  <= 1'b0;
      dp_last   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      dp_start <= 1'b0;
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= in_data ^ rk;
            round     <= 4'd1;
            rk_idx    <= 4'd1;
            dp_start  <= 1'b1;
            dp_last   <= (LAST == 4'd1);
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            fsm       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!NO_WAIT) begin
            wait_cnt <= WAIT_INIT;
            fsm      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            round     <= '0;
            rk_idx    <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase

      // Capture overrides the per-state transitions above: it ends the round.
      if (capture) begin
        state_reg <= next_state;
        if (round == LAST) begin
          out_data  <= next_state;
          out_valid <= 1'b1;
          dp_last   <= 1'b0;
          fsm       <= DONE;
        end else begin
          round    <= round + 4'd1;
          rk_idx   <= round + 4'd1;
          dp_start <= 1'b1;
          dp_last  <= ((round + 4'd1) == LAST);
          fsm      <= ISSUE;
        end
      end
    end
  end

endmodule
